// File: rtl/display_pkg.sv
// Shared constants, state type and segment decoder for the seven-segment number display.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_V     = 7'b1100011;
  localparam logic [6:0] SEG_S     = 7'b0010010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Active-low, bit0 = segment a ... bit6 = segment g.
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex nibble to active-low seven-segment encoder.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = nibble_to_seg(nibble);

endmodule

// File: rtl/seg_number_display.sv
// Binary to N-digit seven-segment display with sequential double-dabble decimal conversion,
// hex mode, leading-zero blanking, overflow dashes and a one-deep pending request.
//
// state  | meaning
// IDLE   | waiting for load_i
// SHIFT  | W conversion cycles (decimal shift-add-3, hex just counts)
// UPDATE | register seg_o/ovf_o, then next request or idle
module seg_number_display
  import display_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [W-1:0]   value_i,
  input  logic           hex_i,
  input  logic           blank_i,
  input  logic           load_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           ovf_o,
  output logic [7*N-1:0] seg_o
);

  if (W < 1 || W > 32 || N < 1 || N > 8) begin : g_param_check
    $error("seg_number_display: W must be 1..32 and N must be 1..8");
  end

  localparam int XW = (W > 4*N) ? W : 4*N;

  state_t         state_q, state_d;
  logic           start;
  logic [5:0]     cnt_q;
  logic [W-1:0]   val_q, bin_q;
  logic [4*N-1:0] bcd_q, bcd_adj;
  logic           carry_q, hex_q, blank_q;
  logic           pend_v_q, pend_hex_q, pend_blank_q;
  logic [W-1:0]   pend_val_q;
  logic [W-1:0]   src_val;
  logic           src_hex, src_blank;
  logic [XW-1:0]  val_ext;
  logic [4*N-1:0] dig;
  logic           ovf_next, lead;
  logic [7*N-1:0] enc, seg_next;
  logic           done_q, ovf_q;
  logic [7*N-1:0] seg_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: if (load_i) begin
        state_d = SHIFT;
        start   = 1'b1;
      end
      SHIFT: if (cnt_q == '0) state_d = UPDATE;
      UPDATE: if (load_i || pend_v_q) begin
        state_d = SHIFT;
        start   = 1'b1;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load in the UPDATE cycle is newer than anything pending, so it wins.
  assign src_val   = load_i ? value_i : pend_val_q;
  assign src_hex   = load_i ? hex_i   : pend_hex_q;
  assign src_blank = load_i ? blank_i : pend_blank_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  assign val_ext  = XW'(val_q);
  assign dig      = hex_q ? val_ext[4*N-1:0] : bcd_q;
  assign ovf_next = hex_q ? ((val_ext >> (4*N)) != '0) : carry_q;

  for (genvar k = 0; k < N; k++) begin : g_enc
    seg7_encode u_enc (.nibble(dig[4*k +: 4]), .seg(enc[7*k +: 7]));
  end

  always_comb begin
    lead     = 1'b1;
    seg_next = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (ovf_next)
        seg_next[7*k +: 7] = SEG_DASH;
      else if (blank_q && lead && k != 0 && dig[4*k +: 4] == 4'd0)
        seg_next[7*k +: 7] = SEG_BLANK;
      else
        seg_next[7*k +: 7] = enc[7*k +: 7];
      if (dig[4*k +: 4] != 4'd0) lead = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      val_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      carry_q      <= 1'b0;
      hex_q        <= 1'b0;
      blank_q      <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_val_q   <= '0;
      pend_hex_q   <= 1'b0;
      pend_blank_q <= 1'b0;
      seg_q        <= {(7*N){1'b1}};
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == UPDATE);

      if (state_q == SHIFT && load_i) begin
        pend_v_q     <= 1'b1;
        pend_val_q   <= value_i;
        pend_hex_q   <= hex_i;
        pend_blank_q <= blank_i;
      end else if (state_q == UPDATE) begin
        pend_v_q <= 1'b0;
      end

      if (state_q == UPDATE) begin
        seg_q <= seg_next;
        ovf_q <= ovf_next;
      end

      if (start) begin
        val_q   <= src_val;
        bin_q   <= src_val;
        hex_q   <= src_hex;
        blank_q <= src_blank;
        bcd_q   <= '0;
        carry_q <= 1'b0;
        cnt_q   <= 6'(W-1);
      end else if (state_q == SHIFT) begin
        if (cnt_q != '0) cnt_q <= cnt_q - 6'd1;
        if (!hex_q) begin
          bcd_q   <= {bcd_adj[4*N-2:0], bin_q[W-1]};
          bin_q   <= bin_q << 1;
          carry_q <= carry_q | bcd_adj[4*N-1];
        end
      end
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign seg_o  = seg_q;

endmodule

// File: tb/tb_seg_number_display.sv
// Four display configurations driven in parallel and checked against an arithmetic reference model.
module tb_seg_number_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] val = '0;
  logic        hex = 1'b0, blank = 1'b0, load = 1'b0;
  logic [3:0]  busy, done, ovf;
  logic [20:0] seg_a, seg_b;
  logic [13:0] seg_c, seg_d;
  logic [55:0] segv [4];
  int tests = 0;
  int fails = 0;

  localparam int WS [4] = '{8, 10, 8, 12};
  localparam int NS [4] = '{3, 3, 2, 2};
  localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_number_display #(.W(8), .N(3)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .value_i(val[7:0]), .hex_i(hex), .blank_i(blank), .load_i(load),
    .busy_o(busy[0]), .done_o(done[0]), .ovf_o(ovf[0]), .seg_o(seg_a));
  seg_number_display #(.W(10), .N(3)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .value_i(val[9:0]), .hex_i(hex), .blank_i(blank), .load_i(load),
    .busy_o(busy[1]), .done_o(done[1]), .ovf_o(ovf[1]), .seg_o(seg_b));
  seg_number_display #(.W(8), .N(2)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .value_i(val[7:0]), .hex_i(hex), .blank_i(blank), .load_i(load),
    .busy_o(busy[2]), .done_o(done[2]), .ovf_o(ovf[2]), .seg_o(seg_c));
  seg_number_display #(.W(12), .N(2)) u_d (
    .clk_i(clk), .rst_n_i(rst_n), .value_i(val), .hex_i(hex), .blank_i(blank), .load_i(load),
    .busy_o(busy[3]), .done_o(done[3]), .ovf_o(ovf[3]), .seg_o(seg_d));

  assign segv[0] = {35'd0, seg_a};
  assign segv[1] = {35'd0, seg_b};
  assign segv[2] = {42'd0, seg_c};
  assign segv[3] = {42'd0, seg_d};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] blank_all(input int n);
    return (56'd1 << (7*n)) - 56'd1;
  endfunction

  // Display as a person would read it: digits by repeated division, dashes if too large.
  function automatic logic [55:0] model(input logic [11:0] v, input logic h, input logic b,
                                        input int w, input int n, output logic o);
    longint unsigned x, base, lim;
    int d [8];
    int msd;
    logic [55:0] r;
    x = longint'(v) & ((64'd1 << w) - 64'd1);
    base = h ? 64'd16 : 64'd10;
    lim = 1;
    for (int k = 0; k < n; k++) lim = lim * base;
    o = (x >= lim);
    msd = 0;
    r = '0;
    for (int k = 0; k < n; k++) begin
      d[k] = int'(x % base);
      x = x / base;
      if (d[k] != 0) msd = k;
    end
    for (int k = 0; k < n; k++)
      r[7*k +: 7] = o ? 7'b0111111 : (b && k > msd) ? 7'h7F : TBL[d[k]];
    return r;
  endfunction

  task automatic run(input logic [11:0] v, input logic h, input logic b);
    int dcnt [4];
    int dcyc [4];
    logic [55:0] sseg [4];
    logic [3:0] sovf;
    logic [55:0] eseg;
    logic eovf;
    for (int i = 0; i < 4; i++) begin dcnt[i] = 0; dcyc[i] = -1; sseg[i] = '0; end
    sovf = '0;
    @(negedge clk); val = v; hex = h; blank = b; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (done[i]) begin dcnt[i]++; dcyc[i] = c; sseg[i] = segv[i]; sovf[i] = ovf[i]; end
    end
    for (int i = 0; i < 4; i++) begin
      eseg = model(v, h, b, WS[i], NS[i], eovf);
      chk($sformatf("done_count[%0d] v=%h", i, v), 64'(dcnt[i]), 64'd1);
      chk($sformatf("done_cycle[%0d] v=%h", i, v), 64'(dcyc[i]), 64'(WS[i] + 1));
      chk($sformatf("seg[%0d] v=%h h=%0d b=%0d", i, v, h, b), 64'(sseg[i]), 64'(eseg));
      chk($sformatf("ovf[%0d] v=%h h=%0d", i, v, h), 64'(sovf[i]), 64'(eovf));
      chk($sformatf("seg_hold[%0d] v=%h", i, v), 64'(segv[i]), 64'(eseg));
      chk($sformatf("busy_idle[%0d]", i), 64'(busy[i]), 64'd0);
    end
  endtask

  task automatic back_to_back();
    int dcnt [4];
    int dcyc [4][2];
    logic [55:0] sseg [4][2];
    logic [3:0] gap_busy;
    logic [55:0] eseg;
    logic eovf;
    for (int i = 0; i < 4; i++) begin
      dcnt[i] = 0;
      for (int j = 0; j < 2; j++) begin dcyc[i][j] = -1; sseg[i][j] = '0; end
    end
    gap_busy = '0;
    @(negedge clk); val = 12'd12; hex = 1'b0; blank = 1'b0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          if (dcnt[i] < 2) begin dcyc[i][dcnt[i]] = c; sseg[i][dcnt[i]] = segv[i]; end
          dcnt[i]++;
        end
        if (c == WS[i] + 1) gap_busy[i] = busy[i];
      end
      if (c == 2) begin val = 12'd34; blank = 1'b0; load = 1'b1; end
      if (c == 3) begin val = 12'd56; blank = 1'b1; end
      if (c == 4) load = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_done_count[%0d]", i), 64'(dcnt[i]), 64'd2);
      chk($sformatf("b2b_first_cycle[%0d]", i), 64'(dcyc[i][0]), 64'(WS[i] + 1));
      chk($sformatf("b2b_second_cycle[%0d]", i), 64'(dcyc[i][1]), 64'(2 * WS[i] + 2));
      chk($sformatf("b2b_no_gap[%0d]", i), 64'(gap_busy[i]), 64'd1);
      eseg = model(12'd12, 1'b0, 1'b0, WS[i], NS[i], eovf);
      chk($sformatf("b2b_first_seg[%0d]", i), 64'(sseg[i][0]), 64'(eseg));
      eseg = model(12'd56, 1'b0, 1'b1, WS[i], NS[i], eovf);
      chk($sformatf("b2b_second_seg[%0d]", i), 64'(sseg[i][1]), 64'(eseg));
    end
  endtask

  initial begin
    int seen_done;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_seg[%0d]", i), 64'(segv[i]), 64'(blank_all(NS[i])));
      chk($sformatf("reset_busy[%0d]", i), 64'(busy[i]), 64'd0);
      chk($sformatf("reset_done[%0d]", i), 64'(done[i]), 64'd0);
      chk($sformatf("reset_ovf[%0d]", i), 64'(ovf[i]), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    run(12'd6, 1'b0, 1'b1);
    run(12'd6, 1'b0, 1'b0);
    run(12'd255, 1'b0, 1'b0);
    run(12'd0, 1'b0, 1'b1);
    run(12'd999, 1'b0, 1'b0);
    run(12'hA7, 1'b1, 1'b0);
    run(12'h1A7, 1'b1, 1'b1);
    run(12'd1000, 1'b0, 1'b0);

    // Reset in the middle of a conversion, with non-blank seg_o and ovf_o set beforehand.
    @(negedge clk); val = 12'd123; hex = 1'b0; blank = 1'b0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midreset_seg[%0d]", i), 64'(segv[i]), 64'(blank_all(NS[i])));
      chk($sformatf("midreset_busy[%0d]", i), 64'(busy[i]), 64'd0);
      chk($sformatf("midreset_ovf[%0d]", i), 64'(ovf[i]), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (done != 4'b0) seen_done++;
    end
    chk("midreset_no_done", 64'(seen_done), 64'd0);

    back_to_back();

    for (int t = 0; t < 20; t++)
      run(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run(12'd5, 1'b0, 1'b1);
    run(12'h0F0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_number_display.md
Name: seg_number_display

Overview:
- Parametrised successor to the fixed-value seven-segment version display.
- Converts a run-time binary value of width W into N active-low seven-segment digits. Decimal conversion is sequential (shift-add-3 / double-dabble, one bit per clock). Hex is also supported.
- Adds a load/busy/done handshake, a one-deep pending request, leading-zero blanking and overflow indication (dashes).
- Sits between control logic (version, note number, parameter values) and the board HEX displays.

Parameters:
- W, 8, binary input width, 1..32.
- N, 3, number of displayed digits, 1..8.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- value_i  in  W  binary value, sampled when load_i=1 is accepted
- hex_i  in  1  1 = hex digits, 0 = decimal; sampled with value_i
- blank_i  in  1  1 = blank leading zeros; sampled with value_i
- load_i  in  1  request pulse/level; each cycle high is one request
- busy_o  out  1  conversion in progress
- done_o  out  1  one-cycle pulse when seg_o has been updated
- ovf_o  out  1  last conversion did not fit in N digits
- seg_o  out  7*N  digit k in bits [7k+6:7k], digit 0 = least significant; bit0=a … bit6=g, active-low

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; seg_o all 7'h7F (blank); busy_o=0, done_o=0, ovf_o=0; pending buffer empty.
- FSM states IDLE, SHIFT, UPDATE.
  - IDLE, load_i=1: capture value_i/hex_i/blank_i into the working regs; clear the BCD reg (4N bits) and the sticky carry flag; bit counter=W-1; go to SHIFT. busy_o=1 from the next cycle.
  - SHIFT, decimal, each cycle:
    - Add 3 to every BCD nibble >=5.
    - Shift {BCD, bin} left by 1.
    - Any 1 shifted out of the BCD MSB sets the sticky carry.
    - Runs exactly W cycles (counter reaches 0), then UPDATE.
  - SHIFT, hex: no arithmetic. The counter still runs W cycles so latency is mode-independent.
  - UPDATE, one cycle:
    - Register seg_o and ovf_o; done_o=1 in the following cycle.
    - If the pending buffer is full, load it into the working regs and go to SHIFT (busy_o stays 1). Otherwise go to IDLE (busy_o=0).
- Latency: load accepted at edge k → seg_o/ovf_o change at edge k+W+1; done_o high for the cycle after that edge only.
- Hex mode:
  - Digit k = value bits [4k+3:4k], zero-extended.
  - Overflow when any value bit at or above position 4N is 1.
- Overflow (decimal carry or hex high bits): ovf_o=1 and every digit shows dash 7'b0111111. Blanking is ignored.
- Blanking (blank_i=1): zero digits above the most significant non-zero digit show 7'h7F. Digit 0 is never blanked, so value 0 shows "0".
- load_i while busy (SHIFT or UPDATE): the request goes to the one-deep pending buffer. A newer request overwrites an older pending one (last wins). Working regs are unaffected.
- load_i in the same cycle as UPDATE: treated as pending, so it is served immediately after the current UPDATE.
- seg_o holds its last value between conversions and never shows intermediate results.
- Reset mid-conversion: everything returns to reset values; the pending request is discarded.
- Elaboration checks: W in 1..32, N in 1..8; otherwise $error.

Decomposition:
- Package display_pkg:
  - Segment constants SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, SEG_V, SEG_S.
  - State enum typedef.
  - Function nibble_to_seg (0-F, active-low).
- Sub-module seg7_encode: combinational 4-bit → 7-bit active-low encoder (0-F), instantiated N times on the final digit vector.

Test Plan:
- W=8, N=3: reset → seg_o=all 7'h7F, busy_o=0, done_o=0, ovf_o=0; assert rst_n_i mid-SHIFT → same values immediately, no done_o.
- W=8, N=3: load value 6, dec, blank=1 → done_o at cycle 10 after load; digits {7F,7F,"6"=7'b0000010}; ovf_o=0. Blank=0 → {"0","0","6"}.
- W=8, N=3: load 255 dec → "2","5","5". Load 0 with blank=1 → only digit 0 = "0" (7'b1000000).
- W=10, N=3: load 1000 dec → ovf_o=1, all dashes. Load 999 → "9","9","9", ovf_o=0.
- W=8, N=2: load 8'hA7 hex → digits "A","7" (7'b0001000, 7'b1111000). W=12, N=2 hex 12'h1A7 → ovf_o=1.
- Back-to-back: load 12, then 34 and 56 during busy → exactly two done_o pulses; first shows 12, second shows 56, no idle gap between conversions.
